mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the fetch stage (IF requester) and the MEM stage (DM requester). Replaces the half-clock address multiplexing.
- Sequences each access over a fixed memory latency and returns registered read data with a one-cycle ready pulse. Requesters stall from their own req/ready pair.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 8: memory address width.
- MEM_LAT, 2: cycles the memory controls are held per access (>=1).
- STARVE_MAX, 3: consecutive DM grants while IF waits before IF is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  cancel the outstanding fetch (branch taken).
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction (registered).
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  32  store data.
- dm_size  in  2  access size: 00 byte, 01 half, 10 word.
- dm_signed  in  1  sign-extend loads.
- dm_ready  out  1  one-cycle pulse: access complete.
- dm_rdata  out  32  load data (registered); 0 after a store.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  32  memory write data.
- mem_AU_inst_sel  out  2  memory access size.
- mem_signed_inst  out  1  memory sign control.
- mem_data_out  in  32  memory read data.

Behaviour:
- Reset (async): state IDLE; all outputs 0; starve count 0; kill flag 0. A reset mid-access aborts the access with no ready pulse.
- States:
  - IDLE: no memory access in progress.
  - FETCH: fetch access in progress.
  - DATA: data access in progress.
- IDLE arbitration, in priority order:
  - dm_req && !(if_req && starve == STARVE_MAX) -> DATA.
  - else if_req -> FETCH.
  - else stay IDLE.
- Accept cycle t:
  - Request fields (address, we, wdata, size, signed) are latched at the end of cycle t.
  - Memory controls are driven from the latched copy during cycles t+1 .. t+MEM_LAT and are 0 otherwise.
  - mem_read = !we for DATA; mem_read = 1 for FETCH. mem_write = we for DATA only.
  - FETCH forces mem_AU_inst_sel = 10 and mem_signed_inst = 0.
- Latency: a down-counter runs MEM_LAT-1 .. 0. When it reaches 0:
  - mem_data_out is captured into the rdata register.
  - The state returns to IDLE.
  - The ready pulse is high in cycle t+MEM_LAT+1.
  - Total request-to-ready time = MEM_LAT+1 cycles.
- Back-to-back: the ready cycle is an IDLE cycle. A req still high in that cycle counts as a new request, so requesters deassert req in the ready cycle unless they want another access. Maximum throughput is one access per MEM_LAT+1 cycles.
- Starvation counter:
  - Increments on each DM grant made while if_req is high, saturating at STARVE_MAX.
  - Clears on any IF grant and whenever if_req is low.
- if_flush:
  - In FETCH: sets the kill flag. The memory access still completes but if_ready is suppressed and if_rdata is unchanged.
  - In IDLE with if_req high: no effect on arbitration; the requester presents the new address.
  - The kill flag clears on return to IDLE.
  - if_flush never affects DATA.
- Stores: dm_rdata is loaded with 0 and dm_ready still pulses.
- Simultaneous ready pulses are impossible: only one access is in flight at a time.
- rdata registers hold their value between pulses.

Decomposition:
- Shared package:
  - State enum: IDLE, FETCH, DATA.
  - Size codes: SZ_BYTE, SZ_HALF, SZ_WORD, matching the memory's AU_inst_sel encoding.
- Natural sub-module: mem_lat_counter. Loadable down-counter with a done flag, reused for the latency timing.
- The starvation counter stays inline.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x10 at cycle 0, memory returns 0x00500093 -> mem_read=1 and mem_addr=0x10 in cycles 1-2; if_ready=1 in cycle 3 with if_rdata=0x00500093.
- Store then load: dm_we=1, addr=0x40, wdata=0xDEADBEEF, size=10 -> mem_write in cycles 1-2, dm_ready in cycle 3 with dm_rdata=0. Then a load from 0x40 returns 0xDEADBEEF with mem_write=0.
- Simultaneous requests: if_req and dm_req both high at cycle 0 -> DATA granted first (dm_ready cycle 3); FETCH accepted in cycle 3, if_ready in cycle 6.
- Starvation: dm_req held high continuously with if_req high, STARVE_MAX=3 -> three DM grants, then the fourth grant goes to IF.
- Flush: if_flush pulsed in cycle 1 of a fetch -> memory still read in cycles 1-2; no if_ready in cycle 3; if_rdata unchanged; the next fetch behaves normally.
- Async reset asserted in cycle 1 of a DATA access -> mem_read, mem_write and dm_ready drop immediately and no ready pulse follows. After release, a new request completes in MEM_LAT+1 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state and access-size encodings for the unified memory port.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter that parks at zero and flags done there.
module mem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_done = r_cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between fetch and data requesters, one access in flight,
// data-first priority with a starvation counter that forces fetch progress.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [1:0]        dm_size,
  input  logic              dm_signed,
  output logic              dm_ready,
  output logic [31:0]       dm_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  output logic [1:0]        mem_AU_inst_sel,
  output logic              mem_signed_inst,
  input  logic [31:0]       mem_data_out
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_signed, r_kill, r_if_ready, r_dm_ready;
  logic [31:0]       r_wdata, r_if_rdata, r_dm_rdata;
  logic [1:0]        r_size;
  logic [SW-1:0]     r_starve;
  logic              w_idle, w_busy, w_dm_grant, w_if_grant, w_done, w_finish, w_kill;
  assign w_idle     = r_state == IDLE;
  assign w_busy     = !w_idle;
  assign w_dm_grant = w_idle && dm_req && !(if_req && r_starve == SW'(STARVE_MAX));
  assign w_if_grant = w_idle && if_req && !w_dm_grant;
  assign w_finish   = w_busy && w_done;
  assign w_kill     = r_kill || if_flush;
  mem_lat_counter #(.W(CW)) u_lat (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_dm_grant || w_if_grant),
    .i_val  (CW'(MEM_LAT - 1)),
    .o_done (w_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_signed   <= 1'b0;
      r_kill     <= 1'b0;
      r_starve   <= '0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state    <= w_dm_grant ? DATA : w_if_grant ? FETCH : w_finish ? IDLE : r_state;
      r_kill     <= w_finish ? 1'b0 : (r_state == FETCH && if_flush) ? 1'b1 : r_kill;
      r_if_ready <= w_finish && r_state == FETCH && !w_kill;
      r_dm_ready <= w_finish && r_state == DATA;
      if (w_finish && r_state == FETCH && !w_kill) r_if_rdata <= mem_data_out;
      if (w_finish && r_state == DATA) r_dm_rdata <= r_we ? 32'd0 : mem_data_out;
      if (!if_req || w_if_grant) r_starve <= '0;
      else if (w_dm_grant && r_starve != SW'(STARVE_MAX)) r_starve <= r_starve + SW'(1);
      // fetches latch as word-sized unsigned reads so the output path needs no state mux
      if (w_dm_grant || w_if_grant) begin
        r_addr   <= w_dm_grant ? dm_addr : if_addr;
        r_we     <= w_dm_grant && dm_we;
        r_wdata  <= w_dm_grant ? dm_wdata : 32'd0;
        r_size   <= w_dm_grant ? dm_size : SZ_WORD;
        r_signed <= w_dm_grant && dm_signed;
      end
    end
  assign if_ready        = r_if_ready;
  assign if_rdata        = r_if_rdata;
  assign dm_ready        = r_dm_ready;
  assign dm_rdata        = r_dm_rdata;
  assign mem_read        = w_busy && !r_we;
  assign mem_write       = w_busy && r_we;
  assign mem_addr        = w_busy ? r_addr : '0;
  assign mem_data_in     = w_busy ? r_wdata : 32'd0;
  assign mem_AU_inst_sel = w_busy ? r_size : 2'b00;
  assign mem_signed_inst = w_busy && r_signed;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboarded bench for the unified memory arbiter with a word memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_signed = 1'b0;
  logic [7:0]  if_addr = '0, dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [1:0]  dm_size = '0;
  logic        if_ready, dm_ready, mem_read, mem_write, mem_signed_inst;
  logic [31:0] if_rdata, dm_rdata, mem_data_in, mem_data_out;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_AU_inst_sel;
  logic [31:0] mem [0:255];
  logic [31:0] q_if[$], q_dm[$];
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(8), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_signed(dm_signed), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_AU_inst_sel(mem_AU_inst_sel), .mem_signed_inst(mem_signed_inst), .mem_data_out(mem_data_out)
  );
  assign mem_data_out = mem[mem_addr];
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8'h10] <= 32'h00500093;
      mem[8'h20] <= 32'h11112222;
      mem[8'h30] <= 32'hAAAA5555;
      mem[8'h34] <= 32'h12345678;
    end else if (mem_write) mem[mem_addr] <= mem_data_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tickn(input int n);
    repeat (n) tick();
  endtask
  task automatic dm(input logic we, input logic [7:0] a, input logic [31:0] wd, input logic [1:0] sz, input logic sg);
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_size = sz; dm_signed = sg; dm_req = 1'b1;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (if_ready) begin
        if (q_if.size() == 0) check("if_ready_unexpected", 32'd1, 32'd0);
        else check("if_rdata", if_rdata, q_if.pop_front());
      end
      if (dm_ready) begin
        if (q_dm.size() == 0) check("dm_ready_unexpected", 32'd1, 32'd0);
        else check("dm_rdata", dm_rdata, q_dm.pop_front());
      end
    end
  initial begin
    tickn(2);
    check("rst_strobes", {28'd0, mem_read, mem_write, if_ready, dm_ready}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    rst = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 8'h10; q_if.push_back(32'h00500093);
    tick();
    check("f_c1_read", {31'd0, mem_read}, 32'd1);
    check("f_c1_addr", {24'd0, mem_addr}, 32'h10);
    check("f_c1_sel", {30'd0, mem_AU_inst_sel}, {30'd0, SZ_WORD});
    tick();
    check("f_c2_read", {31'd0, mem_read}, 32'd1);
    tick();
    check("f_c3_ready", {31'd0, if_ready}, 32'd1);
    check("f_c3_read", {31'd0, mem_read}, 32'd0);
    if_req = 1'b0;
    tick();
    dm(1'b1, 8'h40, 32'hDEADBEEF, SZ_WORD, 1'b0); q_dm.push_back(32'd0);
    tick();
    check("st_c1_write", {30'd0, mem_write, mem_read}, 32'd2);
    check("st_c1_data", mem_data_in, 32'hDEADBEEF);
    check("st_c1_addr", {24'd0, mem_addr}, 32'h40);
    tick();
    check("st_c2_write", {31'd0, mem_write}, 32'd1);
    tick();
    check("st_c3_ready", {31'd0, dm_ready}, 32'd1);
    dm_req = 1'b0;
    tick();
    dm(1'b0, 8'h40, 32'd0, SZ_WORD, 1'b0); q_dm.push_back(32'hDEADBEEF);
    tick();
    check("ld_c1_strobes", {30'd0, mem_write, mem_read}, 32'd1);
    tickn(2);
    check("ld_c3_ready", {31'd0, dm_ready}, 32'd1);
    dm_req = 1'b0;
    tick();
    dm(1'b0, 8'h40, 32'd0, SZ_BYTE, 1'b1); if_req = 1'b1; if_addr = 8'h20;
    q_dm.push_back(32'hDEADBEEF); q_if.push_back(32'h11112222);
    tick();
    check("sim_c1_addr", {24'd0, mem_addr}, 32'h40);
    check("sim_c1_size", {29'd0, mem_signed_inst, mem_AU_inst_sel}, {29'd0, 1'b1, SZ_BYTE});
    tickn(2);
    check("sim_c3_ready", {30'd0, dm_ready, if_ready}, 32'd2);
    dm_req = 1'b0;
    tick();
    check("sim_c4_addr", {24'd0, mem_addr}, 32'h20);
    check("sim_c4_size", {29'd0, mem_signed_inst, mem_AU_inst_sel}, {29'd0, 1'b0, SZ_WORD});
    tickn(2);
    check("sim_c6_ready", {30'd0, dm_ready, if_ready}, 32'd1);
    if_req = 1'b0;
    tick();
    dm(1'b0, 8'h40, 32'd0, SZ_WORD, 1'b0); if_req = 1'b1; if_addr = 8'h20;
    for (int k = 0; k < 3; k++) q_dm.push_back(32'hDEADBEEF);
    q_if.push_back(32'h11112222);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stv_dm_addr", {24'd0, mem_addr}, 32'h40);
      tickn(2);
      check("stv_dm_ready", {30'd0, dm_ready, if_ready}, 32'd2);
    end
    tick();
    check("stv_if_addr", {24'd0, mem_addr}, 32'h20);
    tickn(2);
    check("stv_if_ready", {30'd0, dm_ready, if_ready}, 32'd1);
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 8'h30;
    tick();
    check("fl_c1_addr", {24'd0, mem_addr}, 32'h30);
    if_flush = 1'b1; if_addr = 8'h34;
    tick();
    if_flush = 1'b0;
    check("fl_c2_read", {31'd0, mem_read}, 32'd1);
    check("fl_c2_addr", {24'd0, mem_addr}, 32'h30);
    q_if.push_back(32'h12345678);
    tick();
    check("fl_c3_noready", {31'd0, if_ready}, 32'd0);
    check("fl_c3_rdata", if_rdata, 32'h11112222);
    tick();
    check("fl_c4_addr", {24'd0, mem_addr}, 32'h34);
    tickn(2);
    check("fl_c6_ready", {31'd0, if_ready}, 32'd1);
    if_req = 1'b0;
    tick();
    dm(1'b1, 8'h50, 32'hCAFEF00D, SZ_WORD, 1'b0);
    tick();
    check("ar_c1_write", {31'd0, mem_write}, 32'd1);
    #2 rst = 1'b1;
    #1 check("ar_drop", {29'd0, mem_read, mem_write, dm_ready}, 32'd0);
    dm_req = 1'b0;
    tickn(2);
    rst = 1'b0;
    tickn(3);
    check("ar_no_ready", {31'd0, dm_ready}, 32'd0);
    dm(1'b0, 8'h10, 32'd0, SZ_WORD, 1'b0); q_dm.push_back(32'h00500093);
    tick();
    check("ar_new_read", {31'd0, mem_read}, 32'd1);
    tickn(2);
    check("ar_new_ready", {31'd0, dm_ready}, 32'd1);
    dm_req = 1'b0;
    tickn(2);
    check("if_q_left", q_if.size(), 32'd0);
    check("dm_q_left", q_dm.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
